mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have ports: Clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Start  in  1  request a new operation; sampled on the rising edge.
REQ-004 SHALL have ports: Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: OperandA  in  32  register-file QA value; multiplicand or dividend.
REQ-006 SHALL have ports: OperandB  in  32  register-file QB value; multiplier or divisor.
REQ-007 SHALL have ports: WriteHi, WriteLo  in  1 each  MTHI and MTLO strobes.
REQ-008 SHALL have ports: HiLoIn  in  32  data for MTHI/MTLO; driven from QA.
REQ-009 SHALL have ports: Busy  out  1  operation in progress.
REQ-010 SHALL have ports: Done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: Hi, Lo  out  32 each  architectural HI/LO registers; driven directly from flops.
REQ-012 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept Start only in IDLE or DONE (accept edge E0), latching Op, OperandA and OperandB at E0.
REQ-015 SHALL ignore Start while Busy=1.
REQ-016 SHALL stay in CALC for exactly 32 cycles, performing one radix-2 shift/add (multiply) or restoring shift/subtract (divide) iteration per edge, E1 to E32.
REQ-017 SHALL, in FIX, apply sign correction and update Hi and Lo together at E33, then enter DONE.
REQ-018 SHALL hold Busy=1 from E0 to E33 (33 cycles) and drive Done=1 only in DONE (E33 to E34).
REQ-019 SHALL go from DONE to IDLE when Start=0, or back to CALC when Start=1 (back-to-back operations).
REQ-020 SHALL, for MULT/MULTU, produce the 64-bit signed/unsigned product as {Hi,Lo}.
REQ-021 SHALL, for signed operations, iterate on magnitudes, with sign handling as follows:
- product negative iff operand signs differ;
- quotient negative iff operand signs differ;
- remainder takes the dividend's sign.
REQ-022 SHALL, for DIV/DIVU, produce quotient in Lo and remainder in Hi.
REQ-023 SHALL, for division by zero (DIV or DIVU), set Hi=OperandA and Lo=0xFFFFFFFF, with unchanged latency and no error flag.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, set Lo=0x80000000 and Hi=0x00000000.
REQ-025 SHALL apply WriteHi/WriteLo at the next edge only when Busy=0 and Start is not accepted in the same cycle; otherwise the write is dropped.
REQ-026 SHALL keep Hi and Lo unchanged from E0 until E33; Hi/Lo reads during Busy return the previous values.

Reset
REQ-027 SHALL, on Reset=1, immediately force state=IDLE, Busy=0, Done=0, Hi=0 and Lo=0.
REQ-028 SHALL abort an in-flight operation on reset, with no Hi/Lo update and no Done pulse afterwards.
REQ-029 SHALL take the first Start after Reset deasserts at the following edge.

Structure
REQ-030 SHALL put the Op encodings, the state enum and ITER_COUNT=32 in shared package mdu_pkg.
REQ-031 SHALL use one sub-module, mdu_sign_fix, for combinational magnitude extraction and two's-complement result correction.
REQ-032 SHALL share one 64-bit working register and one 33-bit adder/subtractor between multiply and divide.

Verification
REQ-033 SHALL pass: MULT 0xFFFFFFFE x 0x00000003 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; Done exactly 33 cycles after E0.
REQ-034 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-035 SHALL pass: DIV 0xFFFFFFF9 / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-036 SHALL pass: DIVU 0x00000064 / 0 -> Hi=0x00000064, Lo=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-037 SHALL pass: Start plus a different Op at cycle 5 of a running MULT -> ignored; first result correct. WriteHi=1 (HiLoIn=0x1234) while Busy -> Hi unchanged.
REQ-038 SHALL pass: Reset pulse at cycle 10 of a DIVU -> Busy=0 and Hi=Lo=0 at once; no Done within the next 40 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration count and small op-decode helpers.
package mdu_pkg;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request / result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        WriteHi;
  logic        WriteLo;
  logic [31:0] HiLoIn;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output Start, Op, OperandA, OperandB, WriteHi, WriteLo, HiLoIn,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, WriteHi, WriteLo, HiLoIn,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes on the way in, and
// two's-complement correction of the raw magnitude result on the way out.
module mdu_sign_fix
  import mdu_pkg::*;
(
  input  op_t         op_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        neg_a,
  output logic        neg_b,
  input  op_t         op_q,
  input  logic        neg_a_q,
  input  logic        neg_b_q,
  input  logic [63:0] raw,
  input  logic        div_zero,
  output logic [31:0] hi_fix,
  output logic [31:0] lo_fix
);

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        res_neg;

  // Magnitudes of the incoming operands; unsigned ops pass straight through.
  always_comb begin
    neg_a = op_is_signed(op_in) & a_in[31];
    neg_b = op_is_signed(op_in) & b_in[31];
    mag_a = neg_a ? (~a_in + 32'd1) : a_in;
    mag_b = neg_b ? (~b_in + 32'd1) : b_in;
  end

  // Apply result signs; divide-by-zero forces an all-ones quotient while the
  // remainder naturally comes back as the original dividend.
  always_comb begin
    res_neg  = neg_a_q ^ neg_b_q;
    prod_fix = res_neg ? (~raw + 64'd1) : raw;
    quo_fix  = res_neg ? (~raw[31:0] + 32'd1) : raw[31:0];
    rem_fix  = neg_a_q ? (~raw[63:32] + 32'd1) : raw[63:32];
    if (op_is_div(op_q)) begin
      hi_fix = rem_fix;
      lo_fix = div_zero ? 32'hFFFF_FFFF : quo_fix;
    end else begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
//
//   state | meaning
//   IDLE  | waiting for Start; MTHI/MTLO writes allowed
//   CALC  | 32 shift/add or shift/subtract iterations on magnitudes
//   FIX   | sign correction; HI/LO written at the end of this cycle
//   DONE  | Done pulse; Start here chains the next operation directly
module mul_div_unit
  import mdu_pkg::*;
(
  input logic          Clock,
  input logic          Reset,
  mul_div_unit_if.slave bus
);

  state_t      state, state_nxt;
  logic [5:0]  iter_cnt;
  logic [63:0] work;
  logic [31:0] b_reg;
  op_t         op_q, op_in;
  logic        neg_a_q, neg_b_q;
  logic        accept, write_ok, busy, done;
  logic [31:0] hi_q, lo_q;

  logic [31:0] mag_a, mag_b;
  logic        neg_a, neg_b;
  logic [31:0] hi_fix, lo_fix;

  logic        sub;
  logic [32:0] add_x, add_y, add_sum;
  logic        ge;

  assign op_in = op_t'(bus.Op);

  mdu_sign_fix u_sign_fix (
    .op_in    (op_in),
    .a_in     (bus.OperandA),
    .b_in     (bus.OperandB),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .op_q     (op_q),
    .neg_a_q  (neg_a_q),
    .neg_b_q  (neg_b_q),
    .raw      (work),
    .div_zero (b_reg == 32'd0),
    .hi_fix   (hi_fix),
    .lo_fix   (lo_fix)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; iter_cnt reaching 1 marks the last CALC edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.Start) state_nxt = ST_CALC;
      ST_CALC: if (iter_cnt == 6'd1) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = bus.Start ? ST_CALC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs and qualifiers.
  always_comb begin
    busy     = (state == ST_CALC) || (state == ST_FIX);
    done     = (state == ST_DONE);
    accept   = bus.Start && ((state == ST_IDLE) || (state == ST_DONE));
    write_ok = !busy && !accept;
  end

  // Shared 33-bit adder: add multiplicand for multiply, trial-subtract
  // divisor for divide. A set carry-in bit of the shifted remainder means it
  // already exceeds any 32-bit divisor.
  always_comb begin
    sub     = op_is_div(op_q);
    add_x   = sub ? {work[63:32], work[31]} : {1'b0, work[63:32]};
    add_y   = {1'b0, b_reg};
    add_sum = add_x + (add_y ^ {33{sub}}) + {32'd0, sub};
    ge      = add_x[32] | ~add_sum[32];
  end

  // Operand latch and iteration datapath on the shared working register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      work     <= '0;
      b_reg    <= '0;
      op_q     <= OP_MULT;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      iter_cnt <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      iter_cnt <= 6'(ITER_COUNT);
      if (op_is_div(op_in)) begin
        work  <= {32'd0, mag_a};
        b_reg <= mag_b;
      end else begin
        work  <= {32'd0, mag_b};
        b_reg <= mag_a;
      end
    end else if (state == ST_CALC) begin
      iter_cnt <= iter_cnt - 6'd1;
      if (sub)
        work <= {(ge ? add_sum[31:0] : add_x[31:0]), work[30:0], ge};
      else if (work[0])
        work <= {add_sum, work[31:1]};
      else
        work <= {1'b0, work[63:1]};
    end
  end

  // Architectural HI/LO: result load in FIX, MTHI/MTLO only when idle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end else if (write_ok) begin
      if (bus.WriteHi) hi_q <= bus.HiLoIn;
      if (bus.WriteLo) lo_q <= bus.HiLoIn;
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit with a plain-arithmetic reference.
module tb_mul_div_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation starting from IDLE or DONE; returns with DUT in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int glitch, input bit wr_at_start);
    logic [63:0] res;
    int cyc;
    int hold_err;
    res = ref_model(op, a, b);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = b;
    if (wr_at_start) begin
      bus.WriteHi = 1'b1;
      bus.WriteLo = 1'b1;
      bus.HiLoIn = $urandom;
    end
    tick();
    bus.Start = 1'b0;
    bus.WriteHi = 1'b0;
    bus.WriteLo = 1'b0;
    bus.OperandA = $urandom;
    bus.OperandB = $urandom;
    checks++;
    if (bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy op=%0d got=%b want=1", op, bus.Busy);
    end
    cyc = 0;
    hold_err = 0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      if (bus.Hi !== exp_hi || bus.Lo !== exp_lo || bus.Busy !== 1'b1) hold_err++;
      if (glitch >= 0 && cyc == glitch) begin
        bus.Start = 1'b1;
        bus.Op = ~op;
        bus.OperandA = $urandom;
        bus.OperandB = $urandom;
        bus.WriteHi = 1'b1;
        bus.HiLoIn = 32'h0000_1234;
      end else if (glitch >= 0 && cyc == glitch + 1) begin
        bus.Start = 1'b0;
        bus.WriteHi = 1'b0;
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 33) begin
      failures++;
      $display("FAIL latency op=%0d got=%0d want=33", op, cyc);
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL busy_hold op=%0d bad_cycles=%0d want=0", op, hold_err);
    end
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    checks++;
    if (bus.Hi !== exp_hi || bus.Lo !== exp_lo) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h got=%h_%h want=%h_%h", op, a, b, bus.Hi, bus.Lo, exp_hi, exp_lo);
    end
  endtask

  task automatic check_idle_after(input string tag);
    tick();
    checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_%s got done=%b busy=%b want done=0 busy=0", tag, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.WriteHi = 1'b0;
    bus.WriteLo = 1'b0;
    bus.HiLoIn = '0;
    tick();
    tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus.Busy, bus.Done);
    end
    checks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo got=%h_%h want=0_0", bus.Hi, bus.Lo);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'hFFFF_FFFF || bus.Lo !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_neg got=%h_%h want=ffffffff_fffffffa", bus.Hi, bus.Lo);
    end
    check_idle_after("mult");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'hFFFF_FFFE || bus.Lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max got=%h_%h want=fffffffe_00000001", bus.Hi, bus.Lo);
    end
    check_idle_after("multu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'hFFFF_FFFF || bus.Lo !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_neg got=%h_%h want=ffffffff_fffffffd", bus.Hi, bus.Lo);
    end
    check_idle_after("div");
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'h0000_0064 || bus.Lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL divu_zero got=%h_%h want=00000064_ffffffff", bus.Hi, bus.Lo);
    end
    check_idle_after("divu0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'h0000_0000 || bus.Lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_ovf got=%h_%h want=00000000_80000000", bus.Hi, bus.Lo);
    end
    check_idle_after("divovf");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, -1, 1'b0);
    checks++;
    if (bus.Hi !== 32'hFFFF_FFF9 || bus.Lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_zero_neg got=%h_%h want=fffffff9_ffffffff", bus.Hi, bus.Lo);
    end
    check_idle_after("div0");
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = $urandom;
    bus.WriteHi = 1'b1;
    bus.HiLoIn = v1;
    tick();
    bus.WriteHi = 1'b0;
    exp_hi = v1;
    checks++;
    if (bus.Hi !== exp_hi || bus.Lo !== exp_lo) begin
      failures++;
      $display("FAIL mthi got=%h_%h want=%h_%h", bus.Hi, bus.Lo, exp_hi, exp_lo);
    end
    bus.WriteLo = 1'b1;
    bus.HiLoIn = v2;
    tick();
    bus.WriteLo = 1'b0;
    exp_lo = v2;
    checks++;
    if (bus.Hi !== exp_hi || bus.Lo !== exp_lo) begin
      failures++;
      $display("FAIL mtlo got=%h_%h want=%h_%h", bus.Hi, bus.Lo, exp_hi, exp_lo);
    end
    // write presented together with an accepted Start must be dropped
    run_op(2'b01, $urandom, $urandom, -1, 1'b1);
    check_idle_after("wr_start");
  endtask

  task automatic test_ignore_start();
    run_op(2'b00, $urandom, $urandom, 5, 1'b0);
    check_idle_after("ignore");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), -1, 1'b0);
    check_idle_after("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), -1, 1'b0);
      check_idle_after("rand");
    end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    bus.Start = 1'b1;
    bus.Op = 2'b11;
    bus.OperandA = $urandom;
    bus.OperandB = $urandom_range(1, 1000);
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags got busy=%b done=%b want 0 0", bus.Busy, bus.Done);
    end
    checks++;
    if (bus.Hi !== 32'd0 || bus.Lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_hilo got=%h_%h want=0_0", bus.Hi, bus.Lo);
    end
    #1;
    Reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done active_cycles=%0d want=0", seen_done);
    end
    run_op(2'b10, pick_operand(), pick_operand(), -1, 1'b0);
    check_idle_after("post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
